// File: rtl/gray_decoder_mon_if.sv
// Bus bundle for gray_decoder_mon: raw Gray input and clear request in, decoded
// binary, LED copy, step direction, error status and FSM debug state out.
//
// Handshake: valid_o is a one-cycle strobe that marks the cycle in which
// bin_o/led_o/dir_o/err_o/err_cnt_o first show the newly accepted code.
// There is no ready; the consumer cannot stall the decoder and must sample
// the outputs on the strobe or read the held values later.
interface gray_decoder_mon_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_i;
    logic             clr_err_i;
    logic [WIDTH-1:0] bin_o;
    logic [WIDTH-1:0] led_o;
    logic             valid_o;
    logic             dir_o;
    logic             err_o;
    logic [7:0]       err_cnt_o;
    logic [0:0]       fsm_state;

    modport master (
        output gray_i, clr_err_i,
        input  bin_o, led_o, valid_o, dir_o, err_o, err_cnt_o, fsm_state
    );

    modport slave (
        input  gray_i, clr_err_i,
        output bin_o, led_o, valid_o, dir_o, err_o, err_cnt_o, fsm_state
    );
endinterface

// File: rtl/gray_decoder_mon.sv
// Registered Gray-to-binary decoder with two-flop synchroniser, stability
// filter (debounce), step-direction report and illegal-transition monitor.
module gray_decoder_mon #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    gray_decoder_mon_if.slave bus
);

    localparam int              CW   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] g_acc;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;

    logic [WIDTH-1:0] bin_r;
    logic             valid_r;
    logic             dir_r;
    logic             err_r;
    logic [7:0]       err_cnt_r;

    logic             accept;
    logic [WIDTH-1:0] cand_bin;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             step_up;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Acceptance condition and transition classification against the old code
    always_comb begin
        accept   = (state == SETTLE) && (s2 == cand) && (cand != g_acc) && (cnt == LAST);
        cand_bin = gray2bin(cand);
        diff     = cand ^ g_acc;
        // a single set bit: non-zero and clearing the lowest set bit leaves zero
        one_bit  = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
        step_up  = (cand_bin == WIDTH'(bin_r + 1'b1));
    end

    // Two-flop synchroniser for the asynchronous Gray bus
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.gray_i;
            s2 <= s1;
        end
    end

    // Debounce FSM: a new code must hold for STABLE_CYCLES cycles in SETTLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s2 != g_acc) begin
                        cand  <= s2;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (s2 != cand) begin
                        cand <= s2;
                        cnt  <= '0;
                    end else if (cand == g_acc) begin
                        // input bounced back to the accepted code
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Accept stage: decoded value, strobe and step direction
    always_ff @(posedge clk) begin
        if (rst) begin
            g_acc   <= '0;
            bin_r   <= '0;
            valid_r <= 1'b0;
            dir_r   <= 1'b0;
        end else begin
            valid_r <= accept;
            if (accept) begin
                g_acc <= cand;
                bin_r <= cand_bin;
                if (one_bit) begin
                    dir_r <= step_up;
                end
            end
        end
    end

    // Sticky error flag and saturating counter; an illegal accept beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            if (bus.clr_err_i) begin
                err_r     <= 1'b0;
                err_cnt_r <= '0;
            end
            if (accept && !one_bit) begin
                err_r <= 1'b1;
                if (bus.clr_err_i) begin
                    err_cnt_r <= 8'd1;
                end else if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
        end
    end

    assign bus.bin_o     = bin_r;
    assign bus.led_o     = bin_r;
    assign bus.valid_o   = valid_r;
    assign bus.dir_o     = dir_r;
    assign bus.err_o     = err_r;
    assign bus.err_cnt_o = err_cnt_r;
    assign bus.fsm_state = state;

endmodule
